codma_bus_arbiter: RTL
======================

# codma_bus_arbiter

Round-robin bus scheduler that shares the single codma bus master port between several transfer requesters: the read machine, the write machine and a status/CRC writeback requester. It latches one requester's command, drives the bus request (read or write) with address and size, tracks the granted data beats to completion, and returns done or error to that requester. It sits between the per-function state machines and the top-level bus drive, and is the only block that asserts bus read/write requests.

## Interface
- NUM_REQ, 3: number of requesters; index 0 = read machine, 1 = write machine, 2 = status writer.
- TIMEOUT, 64: maximum ASK cycles without bus_grant_i before abort; must be ≥2.
- clk_i  in  1  clock; all logic rising-edge.
- reset_i  in  1  reset; synchronous, active-high.
- req_i  in  NUM_REQ  per-requester transfer request; held until matching done_o/err_o.
- req_wr_i  in  NUM_REQ  direction per requester; 1 = write, 0 = read.
- req_addr_i  in  NUM_REQ×32  byte address per requester.
- req_size_i  in  NUM_REQ×8  bus size code per requester, forwarded unchanged.
- req_len_i  in  NUM_REQ×3  beats minus one (0 → 1 beat, 7 → 8 beats).
- gnt_o  out  NUM_REQ  one-hot owner; high in ASK and GRANTED.
- done_o  out  NUM_REQ  one-cycle pulse, transfer complete.
- err_o  out  NUM_REQ  one-cycle pulse, grant timeout abort.
- beat_o  out  3  current beat index within transfer (for write-data selection).
- busy_o  out  1  high whenever state ≠ IDLE.
- bus_read_o  out  1  bus read request.
- bus_write_o  out  1  bus write request.
- bus_write_valid_o  out  1  write data valid.
- bus_addr_o  out  32  bus address.
- bus_size_o  out  8  bus size code; 9 when idle.
- bus_grant_i  in  1  bus accepts the pending request.
- bus_valid_i  in  1  one data beat transferred this cycle.

## Operation
- States: IDLE, ASK, GRANTED, DONE, ERROR. Unused encodings → IDLE.
- IDLE: if any req_i, select first asserted index searching from last_q+1 modulo NUM_REQ; latch sel, dir, addr, size, len; → ASK. No request → stay.
- ASK: bus_read_o = !dir, bus_write_o = dir, addr/size from latch. bus_grant_i → GRANTED, wait counter cleared. Wait counter = TIMEOUT−1 without grant → ERROR.
- GRANTED: read/write requests low; addr/size held; bus_write_valid_o = dir. Each bus_valid_i increments beat counter; valid while beat == len → DONE. bus_grant_i ignored here.
- DONE: done_o[sel] = 1, last_q ← sel, → IDLE.
- ERROR: err_o[sel] = 1, last_q ← sel, → IDLE.
- Latched command is stable for the whole transfer; changes on req_* inputs after IDLE are ignored. Requester dropping req_i mid-transfer does not abort it.
- Outputs when not driving (IDLE/DONE/ERROR): bus_read_o, bus_write_o, bus_write_valid_o = 0, bus_addr_o = 0, bus_size_o = 9, gnt_o = 0, beat_o = 0.
- Beat counter is 3 bits, reset to 0 on entry to ASK; never wraps, because completion occurs at len ≤ 7.

## Timing
- Reset: state IDLE, last_q = NUM_REQ−1 (requester 0 wins first arbitration), counters 0, all outputs at idle values, done_o/err_o = 0; effective on the cycle after reset_i is sampled high, including mid-transfer (no done/err pulse issued).
- Request latency: req_i high at edge n → bus request high from cycle n+1.
- Grant: bus_grant_i sampled in ASK at edge m → request deasserted, GRANTED from m+1; minimum ASK duration is 1 cycle.
- Completion: last beat at edge k → done_o pulse in cycle k+1 → IDLE at k+2; earliest next ASK at k+3. Minimum back-to-back gap between transfers: 2 idle bus cycles.
- Timeout: ERROR entered TIMEOUT cycles after ASK entry; err_o pulses the following cycle.
- A requester that just finished re-requesting immediately has lowest priority when others are pending; if it is the only requester, it wins again.

## Test plan
- Single read: req_i=001, addr 0x1000, size 3, len 3; grant after 2 cycles, 4 valids → bus_read_o high 2 cycles, done_o=001 one cycle after 4th beat, beat_o 0→3.
- Contention: req_i=111 held continuously, each transfer len 0 → grant order 0,1,2,0,1,2; gnt_o one-hot at all times.
- Write path: requester 1, len 7 → bus_write_o in ASK, bus_write_valid_o high through GRANTED, done_o=010 after 8th valid; valid gaps do not end transfer early.
- Timeout: TIMEOUT=64, no grant → bus_read_o high exactly 64 cycles, err_o pulse, then IDLE with size 9; next arbitration skips to next requester.
- Reset mid-GRANTED after 2 of 8 beats → next cycle all bus outputs idle, no done/err pulse, next request served to requester 0 first.
- Request drop: req_i deasserted during GRANTED → transfer completes, done_o still pulses.

Source files
------------

// File: rtl/codma_bus_arbiter.sv
// Round-robin owner of the codma bus master port: latches one requester's command,
// runs the ASK/GRANTED handshake and returns a done or timeout-error pulse.
module codma_bus_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ-1:0][31:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][7:0]   req_size_i,
  input  logic [NUM_REQ-1:0][2:0]   req_len_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [2:0]                beat_o,
  output logic                      busy_o,
  output logic                      bus_read_o,
  output logic                      bus_write_o,
  output logic                      bus_write_valid_o,
  output logic [31:0]               bus_addr_o,
  output logic [7:0]                bus_size_o,
  input  logic                      bus_grant_i,
  input  logic                      bus_valid_i
);

  localparam int unsigned SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam logic [7:0]  IDLE_SIZE = 8'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASK     = 3'd1,
    S_GRANTED = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t            state;
  logic [SW-1:0]     last_q;
  logic [SW-1:0]     sel_q;
  logic              dir_q;
  logic [31:0]       addr_q;
  logic [7:0]        size_q;
  logic [2:0]        len_q;
  logic [WW-1:0]     wait_q;

  logic [SW:0]       cand_w;
  logic [SW-1:0]     pick;
  logic              found;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] sel_oh;

  // Rotating search starting just after the previous owner; wrap done by subtraction.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand_w = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_w = {1'b0, last_q} + (SW+1)'(i);
      if (cand_w >= (SW+1)'(NUM_REQ)) cand_w = cand_w - (SW+1)'(NUM_REQ);
      if (!found && req_i[cand_w[SW-1:0]]) begin
        found = 1'b1;
        pick  = cand_w[SW-1:0];
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_comb busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state             <= S_IDLE;
      last_q            <= SW'(NUM_REQ - 1);
      sel_q             <= '0;
      dir_q             <= 1'b0;
      addr_q            <= '0;
      size_q            <= '0;
      len_q             <= '0;
      wait_q            <= '0;
      beat_o            <= '0;
      gnt_o             <= '0;
      done_o            <= '0;
      err_o             <= '0;
      bus_read_o        <= 1'b0;
      bus_write_o       <= 1'b0;
      bus_write_valid_o <= 1'b0;
      bus_addr_o        <= '0;
      bus_size_o        <= IDLE_SIZE;
    end else begin
      // Idle drive values by default; driving states re-assert theirs each cycle.
      done_o            <= '0;
      err_o             <= '0;
      gnt_o             <= '0;
      bus_read_o        <= 1'b0;
      bus_write_o       <= 1'b0;
      bus_write_valid_o <= 1'b0;
      bus_addr_o        <= '0;
      bus_size_o        <= IDLE_SIZE;

      case (state)
        S_IDLE: begin
          beat_o <= '0;
          if (found) begin
            sel_q       <= pick;
            dir_q       <= req_wr_i[pick];
            addr_q      <= req_addr_i[pick];
            size_q      <= req_size_i[pick];
            len_q       <= req_len_i[pick];
            wait_q      <= '0;
            gnt_o       <= pick_oh;
            bus_read_o  <= !req_wr_i[pick];
            bus_write_o <= req_wr_i[pick];
            bus_addr_o  <= req_addr_i[pick];
            bus_size_o  <= req_size_i[pick];
            state       <= S_ASK;
          end
        end

        S_ASK: begin
          if (bus_grant_i) begin
            wait_q            <= '0;
            gnt_o             <= sel_oh;
            bus_write_valid_o <= dir_q;
            bus_addr_o        <= addr_q;
            bus_size_o        <= size_q;
            state             <= S_GRANTED;
          end else if (wait_q == WW'(TIMEOUT - 1)) begin
            err_o <= sel_oh;
            state <= S_ERROR;
          end else begin
            wait_q      <= wait_q + 1'b1;
            gnt_o       <= sel_oh;
            bus_read_o  <= !dir_q;
            bus_write_o <= dir_q;
            bus_addr_o  <= addr_q;
            bus_size_o  <= size_q;
          end
        end

        S_GRANTED: begin
          if (bus_valid_i && (beat_o == len_q)) begin
            done_o <= sel_oh;
            beat_o <= '0;
            state  <= S_DONE;
          end else begin
            if (bus_valid_i) beat_o <= beat_o + 3'd1;
            gnt_o             <= sel_oh;
            bus_write_valid_o <= dir_q;
            bus_addr_o        <= addr_q;
            bus_size_o        <= size_q;
          end
        end

        S_DONE, S_ERROR: begin
          last_q <= sel_q;
          state  <= S_IDLE;
        end

        default: begin
          beat_o <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
